pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage control unit for the pipelined MIPS core. Owns the program counter and arbitrates every next-PC source: reset, exception vector, EX-stage branch redirect, ID-stage jump, hazard stall, instruction-memory wait, and halt. Drives the instruction-memory request and the IF/ID and ID/EX flush lines. Sits between the hazard unit, the ID/EX stages and the instruction memory.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- EXC_VEC, 32'h0000_4180, exception handler address
- BOOT_CYCLES, 0, idle cycles with im_req low after reset release (0..15)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold PC, no fetch advance
- jump_valid  in  1  ID stage resolved j/jal/jr
- jump_target  in  32  jump destination
- branch_taken  in  1  EX stage resolved a taken branch
- branch_target  in  32  branch destination
- exc_req  in  1  exception raised; redirect to EXC_VEC
- halt_req  in  1  break/halt decoded; freeze fetch
- im_ready  in  1  IM delivers the instruction at pc this cycle
- pc  out  32  current fetch address (registered)
- im_req  out  1  fetch request (registered state decode)
- if_valid  out  1  the fetched word is valid for IF/ID this cycle
- flush_ifid  out  1  clear IF/ID on this edge
- flush_idex  out  1  clear ID/EX on this edge

## Operation
- States: RESET, BOOT, RUN, HALT.
- RESET: entered whenever rst=1 at a clock edge, from any state. pc=RESET_PC, im_req=0, boot counter=0.
- Leaving RESET: on the first edge with rst=0, go to BOOT if BOOT_CYCLES>0, otherwise to RUN. pc stays RESET_PC.
- BOOT: counts BOOT_CYCLES cycles with im_req=0, then goes to RUN. Redirect and stall inputs are ignored.
- RUN: im_req=1. Next pc is chosen by strict priority:
  1. exc_req -> EXC_VEC
  2. branch_taken -> branch_target
  3. jump_valid -> jump_target
  4. halt_req -> pc held, go to HALT
  5. stall -> pc held
  6. !im_ready -> pc held (memory wait)
  7. otherwise -> pc+4
- pc+4 wraps modulo 2^32.
- Redirect targets are loaded as given. Bits [1:0] are forced to 0.
- HALT: im_req=0 and pc frozen. Exit only on exc_req (pc=EXC_VEC, state RUN) or rst. Branch and jump inputs are ignored.
- if_valid = im_req & im_ready & !stall & !exc_req & !branch_taken & !jump_valid & !halt_req. This is combinational.
- Flush lines are combinational and apply only in RUN or HALT:
  - exc_req -> both flushes
  - branch_taken -> both flushes
  - jump_valid (alone) -> flush_ifid only
  - stall, halt, or wait -> no flush
- Simultaneous events: the higher priority source wins. Its flush set is asserted; lower sources are dropped and are not queued.

## Timing
- Reset values: pc=RESET_PC, im_req=0, if_valid=0, flush_ifid=0, flush_idex=0, state=RESET.
- With BOOT_CYCLES=0: rst falls before edge k; after edge k, im_req=1 and pc=RESET_PC. After edge k+1, pc=RESET_PC+4 (if im_ready=1 and stall=0).
- Redirect latency is one edge. A request sampled at edge n makes pc=target after edge n. The flush lines clear the pipeline registers at that same edge.
- A stall or wait holds pc for exactly as many cycles as the condition is high. No fetch is lost or duplicated.
- rst mid-operation (any state, any pending redirect): reset wins. The redirect is discarded.

## Structure
- Shared package `cpu_pkg`:
  - state enum (RESET, BOOT, RUN, HALT)
  - RESET_PC and EXC_VEC defaults
  - 32-bit word-address type
- One sub-module, `next_pc_mux`: combinational priority selector that outputs next pc and the flush pair. The FSM, boot counter and pc register stay in pc_sequencer.

## Test plan
- Reset release, BOOT_CYCLES=0, im_ready=1: pc sequence 0x3000, 0x3004, 0x3008. im_req rises on the first edge after rst falls.
- BOOT_CYCLES=3: im_req stays 0 for 3 cycles after reset exit. First fetch is pc=0x3000.
- At pc=0x3010, assert stall for 2 cycles, then im_ready=0 for 1 cycle: pc holds 0x3010 for 3 cycles, then 0x3014. No flushes.
- Same cycle exc_req, branch_taken (0x3100) and jump_valid (0x3200): pc=0x4180. flush_ifid=flush_idex=1. if_valid=0.
- jump_valid with target 0x3203 while stall=1: pc=0x3200. flush_ifid=1, flush_idex=0.
- halt_req at pc=0x3020: im_req=0 and pc stays 0x3020. A branch during HALT is ignored. exc_req gives pc=0x4180 in RUN. rst asserted then gives pc=0x3000 in RESET.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the fetch-stage control of the
//               pipelined MIPS core: sequencer state encoding, default reset
//               and exception addresses, word-address type, and an alignment
//               helper for redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // 32-bit byte address of an instruction word
    typedef logic [31:0] word_t;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam word_t C_RESET_PC = 32'h0000_3000;
    localparam word_t C_EXC_VEC  = 32'h0000_4180;

    // Instructions are word aligned; low address bits of a redirect are dropped
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_mux
// Description : Combinational next-PC priority selector with flush decode.
//   pc            in  32  current fetch address
//   run           in  1   sequencer is in RUN
//   halted        in  1   sequencer is in HALT
//   exc_req       in  1   exception redirect request
//   branch_taken  in  1   EX-stage taken branch
//   branch_target in  32  branch destination
//   jump_valid    in  1   ID-stage jump
//   jump_target   in  32  jump destination
//   halt_req      in  1   halt request
//   stall         in  1   hazard stall
//   im_ready      in  1   instruction memory delivers this cycle
//   next_pc       out 32  address to load at the next edge
//   enter_halt    out 1   RUN should move to HALT
//   flush_ifid    out 1   clear IF/ID at the next edge
//   flush_idex    out 1   clear ID/EX at the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = C_EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic        run,
    input  logic        halted,
    input  logic        exc_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        im_ready,
    output logic [31:0] next_pc,
    output logic        enter_halt,
    output logic        flush_ifid,
    output logic        flush_idex
);

    localparam word_t c_exc_vec = align_word(EXC_VEC);

    always_comb begin
        next_pc    = pc;
        enter_halt = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        if (run) begin
            if (exc_req) begin
                next_pc    = c_exc_vec;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (branch_taken) begin
                next_pc    = align_word(branch_target);
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (jump_valid) begin
                // The jump's own instruction is in ID and must proceed to EX
                next_pc    = align_word(jump_target);
                flush_ifid = 1'b1;
            end else if (halt_req) begin
                enter_halt = 1'b1;
            end else if (!stall && im_ready) begin
                next_pc = pc + 32'd4;
            end
        end else if (halted) begin
            // Only an exception can wake a halted core
            if (exc_req) begin
                next_pc    = c_exc_vec;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage control unit. Owns the program counter, sequences
//               reset/boot/run/halt, and arbitrates all next-PC sources.
//   clk           in  1   clock
//   rst           in  1   synchronous active-high reset
//   stall         in  1   hazard stall
//   jump_valid    in  1   ID-stage jump resolved
//   jump_target   in  32  jump destination
//   branch_taken  in  1   EX-stage taken branch
//   branch_target in  32  branch destination
//   exc_req       in  1   exception request
//   halt_req      in  1   halt request
//   im_ready      in  1   instruction memory delivers word at pc
//   pc            out 32  current fetch address
//   im_req        out 1   fetch request
//   if_valid      out 1   fetched word valid for IF/ID
//   flush_ifid    out 1   clear IF/ID on this edge
//   flush_idex    out 1   clear ID/EX on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = C_RESET_PC,
    parameter logic [31:0] EXC_VEC     = C_EXC_VEC,
    parameter int          BOOT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        halt_req,
    input  logic        im_ready,
    output logic [31:0] pc,
    output logic        im_req,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        flush_idex
);

    // Last count value of the boot window; BOOT lasts BOOT_CYCLES cycles
    localparam logic [3:0] c_boot_last =
        4'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_boot_cnt;
    logic [3:0]  w_boot_cnt_nxt;
    word_t       r_pc;
    word_t       w_next_pc;
    logic        w_run;
    logic        w_halted;
    logic        w_enter_halt;

    assign w_run    = (r_state == ST_RUN);
    assign w_halted = (r_state == ST_HALT);

    next_pc_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_next_pc_mux (
        .pc            (r_pc),
        .run           (w_run),
        .halted        (w_halted),
        .exc_req       (exc_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .stall         (stall),
        .im_ready      (im_ready),
        .next_pc       (w_next_pc),
        .enter_halt    (w_enter_halt),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        case (r_state)
            ST_RESET: begin
                w_boot_cnt_nxt = 4'd0;
                w_state_nxt    = (BOOT_CYCLES > 0) ? ST_BOOT : ST_RUN;
            end
            ST_BOOT: begin
                if (r_boot_cnt == c_boot_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (w_enter_halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (exc_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // State, boot counter and PC registers; reset overrides any pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RESET;
            r_boot_cnt <= 4'd0;
            r_pc       <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_pc       <= w_next_pc;
        end
    end

    assign pc       = r_pc;
    assign im_req   = w_run;
    assign if_valid = im_req & im_ready & ~stall & ~exc_req & ~branch_taken
                    & ~jump_valid & ~halt_req;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Two instances
//               share the stimulus: one without a boot window, one with a
//               three-cycle boot window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_req;
    logic        halt_req;
    logic        im_ready;

    logic [31:0] pc_a, pc_b;
    logic        im_req_a, im_req_b;
    logic        if_valid_a, if_valid_b;
    logic        fl_ifid_a, fl_ifid_b;
    logic        fl_idex_a, fl_idex_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC    (32'h0000_3000),
        .EXC_VEC     (32'h0000_4180),
        .BOOT_CYCLES (0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .halt_req      (halt_req),
        .im_ready      (im_ready),
        .pc            (pc_a),
        .im_req        (im_req_a),
        .if_valid      (if_valid_a),
        .flush_ifid    (fl_ifid_a),
        .flush_idex    (fl_idex_a)
    );

    pc_sequencer #(
        .RESET_PC    (32'h0000_3000),
        .EXC_VEC     (32'h0000_4180),
        .BOOT_CYCLES (3)
    ) u_dut_boot (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .halt_req      (halt_req),
        .im_ready      (im_ready),
        .pc            (pc_b),
        .im_req        (im_req_b),
        .if_valid      (if_valid_b),
        .flush_ifid    (fl_ifid_b),
        .flush_idex    (fl_idex_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let outputs settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall = 0; jump_valid = 0; branch_taken = 0; exc_req = 0; halt_req = 0;
        jump_target = 32'h0; branch_target = 32'h0;
    endtask

    initial begin
        rst = 1; im_ready = 1;
        clear_req();
        step(); step();

        // Reset state
        chk("rst_pc_a", pc_a, 32'h3000);
        chk("rst_imreq_a", {31'b0, im_req_a}, 32'd0);
        chk("rst_ifvalid_a", {31'b0, if_valid_a}, 32'd0);
        chk("rst_flush_a", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        chk("rst_pc_b", pc_b, 32'h3000);
        chk("rst_imreq_b", {31'b0, im_req_b}, 32'd0);

        // Release reset: edge k
        rst = 0;
        step();
        chk("k_imreq_a", {31'b0, im_req_a}, 32'd1);
        chk("k_pc_a", pc_a, 32'h3000);
        chk("k_ifvalid_a", {31'b0, if_valid_a}, 32'd1);
        chk("k_imreq_b", {31'b0, im_req_b}, 32'd0);
        step();
        chk("k1_pc_a", pc_a, 32'h3004);
        chk("k1_imreq_b", {31'b0, im_req_b}, 32'd0);
        step();
        chk("k2_pc_a", pc_a, 32'h3008);
        chk("k2_imreq_b", {31'b0, im_req_b}, 32'd0);
        step();
        chk("k3_imreq_b", {31'b0, im_req_b}, 32'd1);
        chk("k3_pc_b", pc_b, 32'h3000);
        chk("k3_pc_a", pc_a, 32'h300c);
        step();
        chk("k4_pc_a", pc_a, 32'h3010);
        chk("k4_pc_b", pc_b, 32'h3004);

        // Stall 2 cycles, then memory wait 1 cycle
        stall = 1;
        #1;
        chk("stall_ifvalid", {31'b0, if_valid_a}, 32'd0);
        chk("stall_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        step();
        chk("stall1_pc", pc_a, 32'h3010);
        step();
        chk("stall2_pc", pc_a, 32'h3010);
        stall = 0; im_ready = 0;
        #1;
        chk("wait_ifvalid", {31'b0, if_valid_a}, 32'd0);
        chk("wait_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        step();
        chk("wait_pc", pc_a, 32'h3010);
        chk("wait_pc_b", pc_b, 32'h3004);
        im_ready = 1;
        step();
        chk("resume_pc", pc_a, 32'h3014);
        chk("resume_pc_b", pc_b, 32'h3008);

        // Simultaneous exception, branch and jump
        exc_req = 1; branch_taken = 1; branch_target = 32'h3100;
        jump_valid = 1; jump_target = 32'h3200;
        #1;
        chk("multi_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd3);
        chk("multi_ifvalid", {31'b0, if_valid_a}, 32'd0);
        step();
        chk("multi_pc", pc_a, 32'h4180);
        clear_req();
        #1;
        chk("multi_after_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);

        // Jump beats stall; low target bits dropped
        jump_valid = 1; jump_target = 32'h3203; stall = 1;
        #1;
        chk("jump_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd2);
        chk("jump_ifvalid", {31'b0, if_valid_a}, 32'd0);
        step();
        chk("jump_pc", pc_a, 32'h3200);
        clear_req();

        // Branch with flush pair, then wrap at top of address space
        branch_taken = 1; branch_target = 32'hffff_ffff;
        #1;
        chk("br_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd3);
        step();
        chk("br_pc", pc_a, 32'hffff_fffc);
        clear_req();
        step();
        chk("wrap_pc", pc_a, 32'h0000_0000);

        // Branch to 0x3020 then halt
        branch_taken = 1; branch_target = 32'h3020;
        step();
        chk("br2_pc", pc_a, 32'h3020);
        clear_req();
        halt_req = 1;
        #1;
        chk("halt_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        chk("halt_ifvalid", {31'b0, if_valid_a}, 32'd0);
        step();
        chk("halt_pc", pc_a, 32'h3020);
        chk("halt_imreq", {31'b0, im_req_a}, 32'd0);
        halt_req = 0;
        branch_taken = 1; branch_target = 32'h3100;
        jump_valid = 1; jump_target = 32'h3200;
        #1;
        chk("halt_br_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        step();
        chk("halt_br_pc", pc_a, 32'h3020);
        chk("halt_br_imreq", {31'b0, im_req_a}, 32'd0);
        clear_req();
        exc_req = 1;
        #1;
        chk("halt_exc_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd3);
        step();
        chk("halt_exc_pc", pc_a, 32'h4180);
        chk("halt_exc_imreq", {31'b0, im_req_a}, 32'd1);
        clear_req();
        step();
        chk("post_exc_pc", pc_a, 32'h4184);

        // Reset beats a pending redirect
        rst = 1; exc_req = 1; branch_taken = 1; branch_target = 32'h3100;
        step();
        chk("rst_mid_pc", pc_a, 32'h3000);
        chk("rst_mid_imreq", {31'b0, im_req_a}, 32'd0);
        chk("rst_mid_flush", {30'b0, fl_ifid_a, fl_idex_a}, 32'd0);
        chk("rst_mid_ifvalid", {31'b0, if_valid_a}, 32'd0);
        chk("rst_mid_pc_b", pc_b, 32'h3000);
        clear_req();
        rst = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
